// File: rtl/nmr_acq_averager.sv
// nmr_acq_averager: captures ADC shots and sums them coherently into an accumulator RAM, then streams the record out.
// Optional feature macro PHASE_CYCLE_EN adds acq_negate so that a whole shot is subtracted instead of added.
module nmr_acq_averager #(
  parameter int unsigned ADC_W  = 14,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ADC_enable,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [15:0]       num_shots,
  input  logic              arm,
`ifdef PHASE_CYCLE_EN
  input  logic              acq_negate,
`endif
  output logic              busy,
  output logic              done,
  output logic [15:0]       shot_count,
  output logic [ADDR_W:0]   rec_len,
  output logic              overflow,
  output logic [ACC_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_ACQ, S_READOUT} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  logic [15:0]         shot_count_q, shot_count_d, num_shots_q, num_shots_d;
  logic [CNT_W-1:0]    rec_len_q, rec_len_d, idx_q, idx_d, ro_idx_q, ro_idx_d;
  logic                en_prev_q, en_prev_d, negate_q, negate_d, ro_rd_q, ro_rd_d;
  logic [ACC_W-1:0]    m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic                p1_valid_q, p1_valid_d, p1_fwd_q, p1_fwd_d;
  logic [ADDR_W-1:0]   p1_addr_q, p1_addr_d;
  logic [ACC_W-1:0]    p1_sample_q, p1_sample_d, p1_fwd_data_q, p1_fwd_data_d;

  logic [ACC_W-1:0]    mem [DEPTH];
  logic [ACC_W-1:0]    rd_data_q;
  logic [ADDR_W-1:0]   rd_addr_c, wr_addr_c;
  logic                wr_en_c, acq_issue_c, neg_in_c, neg_c;
  logic [ACC_W-1:0]    wr_data_c, acc_sum_c, sample_ext_c, sample_c;

`ifdef PHASE_CYCLE_EN
  assign neg_in_c = acq_negate;
`else
  assign neg_in_c = 1'b0;
`endif

  // Rising-edge cycle uses the live negate input; the rest of the shot uses the latched value.
  assign neg_c        = (state_q == S_WAIT) ? neg_in_c : negate_q;
  assign sample_ext_c = ACC_W'($signed(adc_data));
  assign sample_c     = neg_c ? (ACC_W'(0) - sample_ext_c) : sample_ext_c;

  // Second RMW stage: forwarded sum wins over the RAM read when addresses collided.
  assign acc_sum_c = (p1_fwd_q ? p1_fwd_data_q : rd_data_q) + p1_sample_q;

  always_comb begin
    wr_en_c   = p1_valid_q;
    wr_addr_c = p1_addr_q;
    wr_data_c = acc_sum_c;
    if (state_q == S_CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = ADDR_W'(idx_q);
      wr_data_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
    rd_data_q <= mem[rd_addr_c];
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    overflow_d    = overflow_q;
    shot_count_d  = shot_count_q;
    num_shots_d   = num_shots_q;
    rec_len_d     = rec_len_q;
    idx_d         = idx_q;
    ro_idx_d      = ro_idx_q;
    ro_rd_d       = 1'b0;
    en_prev_d     = ADC_enable;
    negate_d      = negate_q;
    m_data_d      = m_data_q;
    m_valid_d     = m_valid_q;
    m_last_d      = m_last_q;
    p1_valid_d    = 1'b0;
    p1_addr_d     = p1_addr_q;
    p1_sample_d   = p1_sample_q;
    p1_fwd_d      = 1'b0;
    p1_fwd_data_d = p1_fwd_data_q;
    rd_addr_c     = '0;
    acq_issue_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          num_shots_d  = (num_shots == 16'd0) ? 16'd1 : num_shots;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          shot_count_d = '0;
          rec_len_d    = '0;
          busy_d       = 1'b1;
          idx_d        = '0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + CNT_W'(1);
        if (idx_q == CNT_W'(DEPTH - 1)) begin
          idx_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ADC_enable && !en_prev_q) begin
          negate_d    = neg_in_c;
          rd_addr_c   = '0;
          acq_issue_c = 1'b1;
          idx_d       = CNT_W'(1);
          state_d     = S_ACQ;
        end
      end
      S_ACQ: begin
        if (ADC_enable) begin
          if (idx_q < CNT_W'(DEPTH)) begin
            rd_addr_c   = ADDR_W'(idx_q);
            acq_issue_c = 1'b1;
            idx_d       = idx_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          shot_count_d = shot_count_q + 16'd1;
          if (shot_count_q == 16'd0) rec_len_d = idx_q;
          idx_d = '0;
          if (shot_count_d == num_shots_q) begin
            ro_idx_d = '0;
            state_d  = S_READOUT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_READOUT: begin
        if (rec_len_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ro_rd_q) begin
          m_data_d  = rd_data_q;
          m_valid_d = 1'b1;
          m_last_d  = (ro_idx_q == rec_len_q - CNT_W'(1));
        end else if (m_valid_q) begin
          if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (m_last_q) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ro_idx_d  = ro_idx_q + CNT_W'(1);
              rd_addr_c = ADDR_W'(ro_idx_d);
              ro_rd_d   = 1'b1;
            end
          end
        end else begin
          rd_addr_c = ADDR_W'(ro_idx_q);
          ro_rd_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // First RMW stage: launch the read and flag a collision with the write in flight.
    if (acq_issue_c) begin
      p1_valid_d    = 1'b1;
      p1_addr_d     = rd_addr_c;
      p1_sample_d   = sample_c;
      p1_fwd_d      = p1_valid_q && (p1_addr_q == rd_addr_c);
      p1_fwd_data_d = acc_sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      shot_count_q  <= '0;
      num_shots_q   <= '0;
      rec_len_q     <= '0;
      idx_q         <= '0;
      ro_idx_q      <= '0;
      ro_rd_q       <= 1'b0;
      en_prev_q     <= 1'b0;
      negate_q      <= 1'b0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      p1_valid_q    <= 1'b0;
      p1_addr_q     <= '0;
      p1_sample_q   <= '0;
      p1_fwd_q      <= 1'b0;
      p1_fwd_data_q <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      shot_count_q  <= shot_count_d;
      num_shots_q   <= num_shots_d;
      rec_len_q     <= rec_len_d;
      idx_q         <= idx_d;
      ro_idx_q      <= ro_idx_d;
      ro_rd_q       <= ro_rd_d;
      en_prev_q     <= en_prev_d;
      negate_q      <= negate_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      p1_valid_q    <= p1_valid_d;
      p1_addr_q     <= p1_addr_d;
      p1_sample_q   <= p1_sample_d;
      p1_fwd_q      <= p1_fwd_d;
      p1_fwd_data_q <= p1_fwd_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign shot_count = shot_count_q;
  assign rec_len    = rec_len_q;
  assign overflow   = overflow_q;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_nmr_acq_averager.sv
// Scoreboard bench for nmr_acq_averager: expected words queued at stimulus time, monitor pops on each handshake.
module tb_nmr_acq_averager;
  localparam int unsigned ADC_W  = 14;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              ADC_enable;
  logic [ADC_W-1:0]  adc_data;
  logic [15:0]       num_shots;
  logic              arm;
  logic              busy, done, overflow, m_valid, m_last, m_ready;
  logic [15:0]       shot_count;
  logic [ADDR_W:0]   rec_len;
  logic [ACC_W-1:0]  m_data;
`ifdef PHASE_CYCLE_EN
  logic              acq_negate = 1'b0;
`endif

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  nmr_acq_averager dut (
    .clk        (clk),
    .rst        (rst),
    .ADC_enable (ADC_enable),
    .adc_data   (adc_data),
    .num_shots  (num_shots),
    .arm        (arm),
`ifdef PHASE_CYCLE_EN
    .acq_negate (acq_negate),
`endif
    .busy       (busy),
    .done       (done),
    .shot_count (shot_count),
    .rec_len    (rec_len),
    .overflow   (overflow),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [ACC_W-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every accepted word and verify outputs hold during stalls.
  logic             prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_data;
  logic             prev_last;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_valid), 64'(1));
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got data %0h with empty scoreboard", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word_data", 64'(m_data), 64'(e.data));
          check("word_last", 64'(m_last), 64'(e.last));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [15:0] ns);
    num_shots = ns;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(DEPTH + 4);
  endtask

  task automatic window(input int n, input int base, input int step, input int gap);
    for (int i = 0; i < n; i++) begin
      ADC_enable = 1'b1;
      adc_data   = ADC_W'(base + i * step);
      tick(1);
    end
    ADC_enable = 1'b0;
    adc_data   = '0;
    tick(gap);
  endtask

  task automatic finish_run(input string name, input int shots, input int len, input logic ovf,
                            input logic toggle);
    int cyc;
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (toggle) m_ready = ~m_ready;
      tick(1);
      cyc++;
    end
    m_ready = 1'b1;
    tick(2);
    check({name, "_done"}, 64'(done), 64'(1));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_shots"}, 64'(shot_count), 64'(shots));
    check({name, "_rec_len"}, 64'(rec_len), 64'(len));
    check({name, "_overflow"}, 64'(overflow), 64'(ovf));
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ADC_enable = 1'b0; adc_data = '0; num_shots = '0; arm = 1'b0; m_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_rec_len", 64'(rec_len), 64'(0));

    // 1: single ramp shot
    for (int i = 0; i < 20; i++) push(ACC_W'(i), i == 19);
    do_arm(16'd1);
    check("t1_busy", 64'(busy), 64'(1));
    window(20, 0, 1, 3);
    finish_run("t1", 1, 20, 1'b0, 1'b0);

    // 2: four shots of constant -3 with 2-cycle gaps
    for (int i = 0; i < 10; i++) push(ACC_W'(-12), i == 9);
    do_arm(16'd4);
    for (int s = 0; s < 4; s++) window(10, -3, 0, 2);
    finish_run("t2", 4, 10, 1'b0, 1'b0);

    // 3: longer second shot only extends beyond the record
    for (int i = 0; i < 8; i++) push(ACC_W'(6), i == 7);
    do_arm(16'd2);
    window(8, 5, 0, 3);
    window(12, 1, 0, 3);
    finish_run("t3", 2, 8, 1'b0, 1'b0);

    // 4: window longer than DEPTH
    for (int i = 0; i < int'(DEPTH); i++) push(ACC_W'(2), i == int'(DEPTH) - 1);
    do_arm(16'd1);
    window(int'(DEPTH) + 5, 2, 0, 3);
    finish_run("t4", 1, int'(DEPTH), 1'b1, 1'b0);

    // 5: num_shots=0 acts as 1; signed ramp read out with toggling ready
    for (int i = 0; i < 16; i++) push(ACC_W'(-20 + 3 * i), i == 15);
    do_arm(16'd0);
    window(16, -20, 3, 3);
    finish_run("t5", 1, 16, 1'b0, 1'b1);

    // 6: reset mid-acquisition, then a run with an ignored arm during CLEAR
    do_arm(16'd1);
    ADC_enable = 1'b1; adc_data = ADC_W'(3);
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0; ADC_enable = 1'b0; adc_data = '0;
    tick(1);
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_shots", 64'(shot_count), 64'(0));
    check("t6_rst_data", 64'(m_data), 64'(0));
    check("t6_rst_last", 64'(m_last), 64'(0));
    for (int i = 0; i < 4; i++) push(ACC_W'(7), i == 3);
    num_shots = 16'd1;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    tick(500);
    num_shots = 16'd3;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    check("t6_busy_clear", 64'(busy), 64'(1));
    tick(int'(DEPTH) + 4 - 501);
    window(4, 7, 0, 3);
    finish_run("t6", 1, 4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
